decode_stage: RTL and testbench

- Pipeline stage directly downstream of instruction fetch. Consumes the FE/DE latch (PC, IR, fetch-stall bubble flag).
- Reads the register file and tracks in-flight destination registers with a scoreboard. Drives the dependency and branch stall signals back to fetch.
- Produces the DE/EX latch: opcode, register indices, operand values, immediate.
- Updates on negedge I_CLOCK, the same edge fetch uses.

---
 rtl/decode_stage.sv | 147 ++++++++++++++
 tb/tb_decode_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: register file, busy-bit scoreboard and branch-pending tracking that feed the DE/EX latch.
// Optional macro WB_BYPASS_EN forwards the same-cycle writeback into the hazard check and operand reads.
module decode_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int PC_WIDTH   = 16,
  parameter int IR_WIDTH   = 32
) (
  input  logic                  I_CLOCK,
  input  logic                  I_LOCK,
  input  logic [PC_WIDTH-1:0]   I_PC,
  input  logic [IR_WIDTH-1:0]   I_IR,
  input  logic                  I_FetchStall,
  input  logic                  I_FRAMESTALL,
  input  logic                  I_WriteBackEnable,
  input  logic [3:0]            I_WriteBackRegIdx,
  input  logic [DATA_WIDTH-1:0] I_WriteBackData,
  input  logic                  I_BranchAddrSelect,
  output logic                  O_LOCK,
  output logic [PC_WIDTH-1:0]   O_PC,
  output logic [7:0]            O_Opcode,
  output logic [3:0]            O_DestRegIdx,
  output logic [DATA_WIDTH-1:0] O_Src1Value,
  output logic [DATA_WIDTH-1:0] O_Src2Value,
  output logic [DATA_WIDTH-1:0] O_Imm,
  output logic                  O_DepStallOut,
  output logic                  O_DepStallSignal,
  output logic                  O_BranchStallSignal
);

  localparam logic [3:0] CLS_ALU_RR = 4'h0;
  localparam logic [3:0] CLS_ALU_RI = 4'h1;
  localparam logic [3:0] CLS_LOAD   = 4'h2;
  localparam logic [3:0] CLS_STORE  = 4'h3;
  localparam logic [3:0] CLS_BRANCH = 4'h4;
  localparam logic [3:0] CLS_JUMP   = 4'h5;
  localparam logic [7:0] OPCODE_NOP = 8'hFF;

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_eff;
  logic [NUM_REGS-1:0]   wb_clear;
  logic [NUM_REGS-1:0]   dst_set;
  logic                  branch_pending;

  logic [3:0]            cls;
  logic [3:0]            dst;
  logic [3:0]            src1;
  logic [3:0]            src2;
  logic                  cls_valid;
  logic                  reads_src1;
  logic                  reads_src2;
  logic                  writes_dst;
  logic                  is_branch;
  logic                  dep_hazard;
  logic                  dep_stall;
  logic                  issue;
  logic [DATA_WIDTH-1:0] src1_value;
  logic [DATA_WIDTH-1:0] src2_value;

  assign cls  = I_IR[31:28];
  assign dst  = I_IR[23:20];
  assign src1 = I_IR[19:16];
  assign src2 = I_IR[11:8];

  // NOTE: every output gets a default before the case, so no path can leave a latch behind.
  always_comb begin
    cls_valid  = 1'b0;
    reads_src1 = 1'b0;
    reads_src2 = 1'b0;
    writes_dst = 1'b0;
    is_branch  = 1'b0;
    case (cls)
      CLS_ALU_RR: begin cls_valid = 1'b1; reads_src1 = 1'b1; reads_src2 = 1'b1; writes_dst = 1'b1; end
      CLS_ALU_RI: begin cls_valid = 1'b1; reads_src1 = 1'b1; writes_dst = 1'b1; end
      CLS_LOAD:   begin cls_valid = 1'b1; reads_src1 = 1'b1; writes_dst = 1'b1; end
      CLS_STORE:  begin cls_valid = 1'b1; reads_src1 = 1'b1; reads_src2 = 1'b1; end
      CLS_BRANCH: begin cls_valid = 1'b1; reads_src1 = 1'b1; reads_src2 = 1'b1; is_branch = 1'b1; end
      CLS_JUMP:   begin cls_valid = 1'b1; is_branch = 1'b1; end
      default:    ;
    endcase
  end

  always_comb begin
    wb_clear = '0;
    if (I_WriteBackEnable) wb_clear[I_WriteBackRegIdx] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign busy_eff   = busy & ~wb_clear;
  assign src1_value = (I_WriteBackEnable && I_WriteBackRegIdx == src1) ? I_WriteBackData : rf[src1];
  assign src2_value = (I_WriteBackEnable && I_WriteBackRegIdx == src2) ? I_WriteBackData : rf[src2];
`else
  assign busy_eff   = busy;
  assign src1_value = rf[src1];
  assign src2_value = rf[src2];
`endif

  // The destination field is checked for every valid class, not only for register writers.
  assign dep_hazard = busy_eff[dst] | (reads_src1 & busy_eff[src1]) | (reads_src2 & busy_eff[src2]);
  assign dep_stall  = ~I_FetchStall & cls_valid & dep_hazard;
  assign issue      = ~I_FRAMESTALL & ~I_FetchStall & cls_valid & ~dep_hazard & ~branch_pending;

  assign O_DepStallSignal    = dep_stall;
  assign O_BranchStallSignal = branch_pending | (is_branch & dep_stall);

  always_comb begin
    dst_set = '0;
    if (issue && writes_dst) dst_set[dst] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(negedge I_CLOCK) begin
    O_LOCK <= I_LOCK;
    if (!I_LOCK) begin
      // NOTE: the register file is cleared explicitly; software relies on every register reading 0 after reset.
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      busy           <= '0;
      branch_pending <= 1'b0;
      O_PC           <= '0;
      O_Opcode       <= OPCODE_NOP;
      O_DestRegIdx   <= '0;
      O_Src1Value    <= '0;
      O_Src2Value    <= '0;
      O_Imm          <= '0;
      O_DepStallOut  <= 1'b1;
    end else if (!I_FRAMESTALL) begin
      if (I_WriteBackEnable) rf[I_WriteBackRegIdx] <= I_WriteBackData;
      // A same-edge issue to the writeback register keeps it busy: the set is applied after the clear.
      busy           <= (busy & ~wb_clear) | dst_set;
      branch_pending <= (issue & is_branch) | (branch_pending & ~I_BranchAddrSelect);
      if (issue) begin
        O_PC          <= I_PC;
        O_Opcode      <= I_IR[31:24];
        O_DestRegIdx  <= dst;
        O_Src1Value   <= src1_value;
        O_Src2Value   <= src2_value;
        O_Imm         <= DATA_WIDTH'(I_IR[15:0]);
        O_DepStallOut <= 1'b0;
      end else begin
        O_Opcode      <= OPCODE_NOP;
        O_DepStallOut <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, hand-written multi-cycle sequences, then random
// stimulus against a rule-level reference model. Honours WB_BYPASS_EN when it is defined.
module tb_decode_stage;

  localparam logic [31:0] NOP_IR = 32'hF000_0000;
`ifdef WB_BYPASS_EN
  localparam int BYPASS = 1;
`else
  localparam int BYPASS = 0;
`endif

  logic        clk = 1'b0;
  logic        lock;
  logic [15:0] pc;
  logic [31:0] ir;
  logic        fetch_stall;
  logic        frame_stall;
  logic        wb_en;
  logic [3:0]  wb_idx;
  logic [15:0] wb_data;
  logic        br_sel;

  logic        o_lock;
  logic [15:0] o_pc;
  logic [7:0]  o_opcode;
  logic [3:0]  o_dst;
  logic [15:0] o_src1;
  logic [15:0] o_src2;
  logic [15:0] o_imm;
  logic        o_dso;
  logic        o_dep_sig;
  logic        o_br_sig;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] pc_ctr = 16'h1000;

  always #5 clk = ~clk;

  decode_stage dut (
    .I_CLOCK             (clk),
    .I_LOCK              (lock),
    .I_PC                (pc),
    .I_IR                (ir),
    .I_FetchStall        (fetch_stall),
    .I_FRAMESTALL        (frame_stall),
    .I_WriteBackEnable   (wb_en),
    .I_WriteBackRegIdx   (wb_idx),
    .I_WriteBackData     (wb_data),
    .I_BranchAddrSelect  (br_sel),
    .O_LOCK              (o_lock),
    .O_PC                (o_pc),
    .O_Opcode            (o_opcode),
    .O_DestRegIdx        (o_dst),
    .O_Src1Value         (o_src1),
    .O_Src2Value         (o_src2),
    .O_Imm               (o_imm),
    .O_DepStallOut       (o_dso),
    .O_DepStallSignal    (o_dep_sig),
    .O_BranchStallSignal (o_br_sig)
  );

  typedef struct {
    logic [31:0] ir;
    logic        fs;
    logic        wbe;
    logic [3:0]  wbi;
    logic [15:0] wbd;
    logic        bsel;
    logic        e_dsig;
    logic        e_bsig;
    logic [7:0]  e_op;
    logic        e_dso;
    logic [3:0]  e_dst;
    logic [15:0] e_s1;
    logic [15:0] e_s2;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic [31:0] v_ir, input logic v_fs, input logic v_wbe,
                              input logic [3:0] v_wbi, input logic [15:0] v_wbd, input logic v_bsel,
                              input logic v_dsig, input logic v_bsig, input logic [7:0] v_op,
                              input logic v_dso, input logic [3:0] v_dst,
                              input logic [15:0] v_s1, input logic [15:0] v_s2);
    vec_t v;
    v.ir = v_ir; v.fs = v_fs; v.wbe = v_wbe; v.wbi = v_wbi; v.wbd = v_wbd; v.bsel = v_bsel;
    v.e_dsig = v_dsig; v.e_bsig = v_bsig; v.e_op = v_op; v.e_dso = v_dso;
    v.e_dst = v_dst; v.e_s1 = v_s1; v.e_s2 = v_s2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after posedge; combinational outputs are sampled 1 time unit later.
  task automatic apply(input logic [31:0] a_ir, input logic a_fs, input logic a_frz, input logic a_wbe,
                       input logic [3:0] a_wbi, input logic [15:0] a_wbd, input logic a_bsel);
    ir = a_ir; fetch_stall = a_fs; frame_stall = a_frz; wb_en = a_wbe;
    wb_idx = a_wbi; wb_data = a_wbd; br_sel = a_bsel; pc = pc_ctr;
    #1;
  endtask

  task automatic run_ir(input logic [31:0] a_ir);
    apply(a_ir, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
  endtask

  // The DUT updates on negedge; registered outputs are read at the following posedge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    pc_ctr = pc_ctr + 16'd4;
  endtask

  task automatic do_reset();
    lock = 1'b0;
    run_ir(NOP_IR);
    tick();
    lock = 1'b1;
  endtask

  // Reference model state: architectural registers, busy set, branch-pending and the DE/EX latch.
  logic [15:0] m_rf [16];
  bit          m_busy [16];
  bit          m_pending;
  logic [15:0] e_pc, e_s1, e_s2, e_imm;
  logic [7:0]  e_op;
  logic [3:0]  e_dst;
  logic        e_dso;

  logic [31:0] r_ir;
  logic [3:0]  r_cls, r_d, r_a, r_b, r_wbi;
  logic [15:0] r_wbd, v1, v2, issue_pc;
  bit          r_fs, r_frz, r_wbe, r_bsel;
  bit          valid, rd1, rd2, wr, br, haz, go, e_dsig, e_bsig;
  bit          view [16];
  int          n_wait;

  initial begin
    vecs[0]  = mk(32'h01312000, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 8'h01, 0, 4'd3, 16'h0000, 16'h0000);
    vecs[1]  = mk(32'h01430000, 0, 0, 4'd0, 16'h0000, 0, 1, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[2]  = mk(32'h01430000, 1, 0, 4'd0, 16'h0000, 0, 0, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[3]  = mk(NOP_IR,       0, 1, 4'd3, 16'h00AA, 0, 0, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[4]  = mk(32'h01430000, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 8'h01, 0, 4'd4, 16'h00AA, 16'h0000);
    vecs[5]  = mk(32'h10500007, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 8'h10, 0, 4'd5, 16'h0000, 16'h0000);
    vecs[6]  = mk(32'h30060300, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 8'h30, 0, 4'd0, 16'h0000, 16'h00AA);
    vecs[7]  = mk(32'h30050000, 0, 0, 4'd0, 16'h0000, 0, 1, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[8]  = mk(32'h50400000, 0, 0, 4'd0, 16'h0000, 0, 1, 1, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[9]  = mk(NOP_IR,       0, 1, 4'd4, 16'h1234, 0, 0, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[10] = mk(NOP_IR,       0, 1, 4'd5, 16'h5555, 0, 0, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[11] = mk(32'h40120000, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 8'h40, 0, 4'd1, 16'h0000, 16'h0000);
    vecs[12] = mk(32'h01312000, 0, 0, 4'd0, 16'h0000, 0, 0, 1, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[13] = mk(32'h01312000, 0, 0, 4'd0, 16'h0000, 1, 0, 1, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[14] = mk(32'h01312000, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 8'h01, 0, 4'd3, 16'h0000, 16'h0000);
    vecs[15] = mk(32'h00500000, 0, 1, 4'd5, 16'h0BEE, 0, 0, 0, 8'h00, 0, 4'd5, 16'h0000, 16'h0000);
    vecs[16] = mk(32'h01650000, 0, 0, 4'd0, 16'h0000, 0, 1, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[17] = mk(NOP_IR,       0, 1, 4'd5, 16'h5A5A, 0, 0, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[18] = mk(32'h01650000, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 8'h01, 0, 4'd6, 16'h5A5A, 16'h0000);
    vecs[19] = mk(32'h00720300, 0, 0, 4'd0, 16'h0000, 0, 1, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[20] = mk(NOP_IR,       0, 1, 4'd3, 16'h0033, 0, 0, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);
    vecs[21] = mk(32'h00720300, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 8'h00, 0, 4'd7, 16'h0000, 16'h0033);
    vecs[22] = mk(32'h11800600, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 8'h11, 0, 4'd8, 16'h0000, 16'h0000);
    vecs[23] = mk(32'h67600000, 0, 0, 4'd0, 16'h0000, 0, 0, 0, 8'hFF, 1, 4'd0, 16'h0000, 16'h0000);

    lock = 1'b0;
    run_ir(NOP_IR);
    @(posedge clk);

    // Reset state
    do_reset();
    check("rst_opcode", o_opcode, 8'hFF);
    check("rst_dso", o_dso, 1'b1);
    check("rst_lock", o_lock, 1'b0);
    check("rst_pc", o_pc, 16'h0000);
    check("rst_dst", o_dst, 4'd0);
    check("rst_src1", o_src1, 16'h0000);
    check("rst_src2", o_src2, 16'h0000);
    check("rst_imm", o_imm, 16'h0000);
    run_ir(NOP_IR);
    check("rst_dep_sig", o_dep_sig, 1'b0);
    check("rst_br_sig", o_br_sig, 1'b0);

    // Directed vector table
    for (int i = 0; i < 24; i++) begin
      apply(vecs[i].ir, vecs[i].fs, 1'b0, vecs[i].wbe, vecs[i].wbi, vecs[i].wbd, vecs[i].bsel);
      issue_pc = pc_ctr;
      check($sformatf("T%0d_dep_sig", i), o_dep_sig, vecs[i].e_dsig);
      check($sformatf("T%0d_br_sig", i), o_br_sig, vecs[i].e_bsig);
      tick();
      check($sformatf("T%0d_opcode", i), o_opcode, vecs[i].e_op);
      check($sformatf("T%0d_dso", i), o_dso, vecs[i].e_dso);
      check($sformatf("T%0d_lock", i), o_lock, 1'b1);
      if (!vecs[i].e_dso) begin
        check($sformatf("T%0d_pc", i), o_pc, issue_pc);
        check($sformatf("T%0d_dst", i), o_dst, vecs[i].e_dst);
        check($sformatf("T%0d_src1", i), o_src1, vecs[i].e_s1);
        check($sformatf("T%0d_src2", i), o_src2, vecs[i].e_s2);
        check($sformatf("T%0d_imm", i), o_imm, vecs[i].ir[15:0]);
      end
    end

    // Dependent issue relative to its producer's writeback
    do_reset();
    run_ir(32'h01312000); tick();
    check("A_prod_op", o_opcode, 8'h01);
    run_ir(32'h01430000);
    check("A_dep_sig", o_dep_sig, 1'b1);
    tick();
    check("A_bubble", o_dso, 1'b1);
    n_wait = 0;
    for (int k = 0; k < 3; k++) begin
      apply(32'h01430000, 1'b0, 1'b0, k == 0, 4'd3, 16'h00AA, 1'b0);
      tick();
      if (o_dso == 1'b0) break;
      n_wait++;
    end
    check("A_issue_delay", n_wait, BYPASS ? 0 : 1);
    check("A_src1", o_src1, 16'h00AA);
    check("A_dst", o_dst, 4'd4);

    // Branch waiting on an operand, then squashing until resolved
    do_reset();
    run_ir(32'h01100000); tick();
    check("B_prod_op", o_opcode, 8'h01);
    run_ir(32'h40120000);
    check("B_wait_br", o_br_sig, 1'b1);
    check("B_wait_dep", o_dep_sig, 1'b1);
    tick();
    check("B_wait_bubble", o_dso, 1'b1);
    n_wait = 0;
    for (int k = 0; k < 3; k++) begin
      apply(32'h40120000, 1'b0, 1'b0, k == 0, 4'd1, 16'h0101, 1'b0);
      tick();
      if (o_dso == 1'b0) break;
      n_wait++;
    end
    check("B_issue_delay", n_wait, BYPASS ? 0 : 1);
    check("B_op", o_opcode, 8'h40);
    run_ir(32'h01312000);
    check("B_pend_br", o_br_sig, 1'b1);
    check("B_pend_dep", o_dep_sig, 1'b0);
    tick();
    check("B_squash", o_dso, 1'b1);
    apply(32'h01312000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    check("B_resolve_br", o_br_sig, 1'b1);
    tick();
    check("B_squash_resolve", o_dso, 1'b1);
    run_ir(32'h01312000);
    check("B_cleared_br", o_br_sig, 1'b0);
    tick();
    check("B_after_op", o_opcode, 8'h01);
    check("B_after_src1", o_src1, 16'h0101);

    // Frame stall freezes outputs, writeback and scoreboard
    do_reset();
    run_ir(32'h09900000);
    issue_pc = pc_ctr;
    tick();
    check("C_prod_op", o_opcode, 8'h09);
    for (int k = 0; k < 3; k++) begin
      apply(32'h0AB00000, 1'b0, 1'b1, 1'b1, 4'd9, 16'h9999, 1'b0);
      tick();
      check("C_frozen_op", o_opcode, 8'h09);
      check("C_frozen_dso", o_dso, 1'b0);
      check("C_frozen_dst", o_dst, 4'd9);
      check("C_frozen_pc", o_pc, issue_pc);
    end
    run_ir(32'h0AB00000); tick();
    check("C_release_op", o_opcode, 8'h0A);
    check("C_release_dst", o_dst, 4'd11);
    run_ir(32'h0CC90000);
    check("C_busy_kept", o_dep_sig, 1'b1);
    tick();
    check("C_busy_bubble", o_dso, 1'b1);

    // Reset in the middle of a pending branch with a busy register
    do_reset();
    apply(NOP_IR, 1'b0, 1'b0, 1'b1, 4'd2, 16'h2222, 1'b0); tick();
    run_ir(32'h02200000); tick();
    run_ir(32'h50000000); tick();
    check("D_jump_op", o_opcode, 8'h50);
    run_ir(32'h01020000);
    check("D_pending", o_br_sig, 1'b1);
    check("D_busy2", o_dep_sig, 1'b1);
    lock = 1'b0;
    tick();
    check("D_rst_op", o_opcode, 8'hFF);
    check("D_rst_dso", o_dso, 1'b1);
    check("D_rst_lock", o_lock, 1'b0);
    check("D_rst_pc", o_pc, 16'h0000);
    lock = 1'b1;
    run_ir(32'h01020000);
    check("D_after_br", o_br_sig, 1'b0);
    check("D_after_dep", o_dep_sig, 1'b0);
    tick();
    check("D_after_op", o_opcode, 8'h01);
    check("D_after_src1", o_src1, 16'h0000);
    check("D_after_lock", o_lock, 1'b1);

    // Random stimulus against the reference model
    do_reset();
    for (int k = 0; k < 16; k++) begin m_rf[k] = 16'h0000; m_busy[k] = 1'b0; end
    m_pending = 1'b0;
    e_pc = 16'h0000; e_op = 8'hFF; e_dst = 4'd0; e_s1 = 16'h0000; e_s2 = 16'h0000;
    e_imm = 16'h0000; e_dso = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r_ir = $urandom;
      case ($urandom_range(0, 7))
        0: r_cls = 4'h0; 1: r_cls = 4'h1; 2: r_cls = 4'h2; 3: r_cls = 4'h3;
        4: r_cls = 4'h4; 5: r_cls = 4'h5; 6: r_cls = 4'hF; default: r_cls = 4'h7;
      endcase
      r_d = 4'($urandom_range(0, 7)); r_a = 4'($urandom_range(0, 7)); r_b = 4'($urandom_range(0, 7));
      r_ir[31:28] = r_cls; r_ir[23:20] = r_d; r_ir[19:16] = r_a; r_ir[11:8] = r_b;
      r_fs   = ($urandom_range(0, 9) == 0);
      r_frz  = ($urandom_range(0, 11) == 0);
      r_wbe  = ($urandom_range(0, 9) < 3);
      r_wbi  = 4'($urandom_range(0, 7));
      r_wbd  = 16'($urandom);
      r_bsel = ($urandom_range(0, 3) == 0);

      valid = r_cls inside {[4'h0:4'h5]};
      rd1   = r_cls inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
      rd2   = r_cls inside {4'h0, 4'h3, 4'h4};
      wr    = r_cls inside {4'h0, 4'h1, 4'h2};
      br    = r_cls inside {4'h4, 4'h5};
      for (int k = 0; k < 16; k++) view[k] = m_busy[k] && !(BYPASS != 0 && r_wbe && r_wbi == 4'(k));
      haz    = view[r_d] || (rd1 && view[r_a]) || (rd2 && view[r_b]);
      e_dsig = !r_fs && valid && haz;
      e_bsig = m_pending || (br && e_dsig);
      go     = !r_frz && !r_fs && valid && !haz && !m_pending;
      v1 = (BYPASS != 0 && r_wbe && r_wbi == r_a) ? r_wbd : m_rf[r_a];
      v2 = (BYPASS != 0 && r_wbe && r_wbi == r_b) ? r_wbd : m_rf[r_b];

      apply(r_ir, r_fs, r_frz, r_wbe, r_wbi, r_wbd, r_bsel);
      check("R_dep_sig", o_dep_sig, e_dsig);
      check("R_br_sig", o_br_sig, e_bsig);

      if (!r_frz) begin
        if (go) begin
          e_pc = pc_ctr; e_op = r_ir[31:24]; e_dst = r_d; e_s1 = v1; e_s2 = v2;
          e_imm = r_ir[15:0]; e_dso = 1'b0;
        end else begin
          e_op = 8'hFF; e_dso = 1'b1;
        end
        if (r_wbe) begin m_rf[r_wbi] = r_wbd; m_busy[r_wbi] = 1'b0; end
        if (go && wr) m_busy[r_d] = 1'b1;
        m_pending = (go && br) || (m_pending && !r_bsel);
      end

      tick();
      check("R_opcode", o_opcode, e_op);
      check("R_dso", o_dso, e_dso);
      check("R_pc", o_pc, e_pc);
      check("R_dst", o_dst, e_dst);
      check("R_src1", o_src1, e_s1);
      check("R_src2", o_src2, e_s2);
      check("R_imm", o_imm, e_imm);
      check("R_lock", o_lock, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
